// File: rtl/reg_bank_pkg.sv
// Shared types and helpers for the multi-port register bank.
// The write-port priority helper handles up to MAX_PORTS write ports.
package reg_bank_pkg;

  localparam int unsigned DEF_DATA_W   = 32;
  localparam int unsigned DEF_NUM_REGS = 32;
  localparam int unsigned DEF_ADDR_W   = $clog2(DEF_NUM_REGS);
  localparam int unsigned MAX_PORTS    = 16;

  typedef logic [DEF_ADDR_W-1:0] reg_addr_t;
  typedef logic [DEF_DATA_W-1:0] reg_data_t;

  // True when port k matches and no higher-index port also matches.
  function automatic logic is_winner(input logic [MAX_PORTS-1:0] hit, input int unsigned k);
    logic [MAX_PORTS-1:0] above;
    above = hit >> k;
    return above[0] && (above[MAX_PORTS-1:1] == '0);
  endfunction

endpackage

// File: rtl/reg_bank_sb.sv
// Busy scoreboard: tracks registers with an issued but not yet written-back producer.
module reg_bank_sb
  import reg_bank_pkg::*;
#(
  parameter int unsigned NUM_REGS = DEF_NUM_REGS,
  parameter int unsigned ADDR_W   = $clog2(NUM_REGS),
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned NUM_WR   = 2,
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic                     clk,
  input  logic                     arst_n,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  input  logic [NUM_RD-1:0]        rd_fwd,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_addr,
  output logic [NUM_REGS-1:0]      busy_vec,
  output logic [NUM_RD-1:0]        rd_busy
);

  logic [NUM_REGS-1:0] busy_nxt;
  logic [ADDR_W-1:0]   wa [NUM_WR];
  logic [ADDR_W-1:0]   ra [NUM_RD];

  for (genvar k = 0; k < NUM_WR; k++) begin : g_wa
    assign wa[k] = wr_addr[k*ADDR_W +: ADDR_W];
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_ra
    assign ra[p] = rd_addr[p*ADDR_W +: ADDR_W];
  end

  // Writebacks clear first so a same-cycle issue (newer producer) wins.
  always_comb begin
    busy_nxt = busy_vec;
    for (int unsigned k = 0; k < NUM_WR; k++) begin
      if (wr_en[k]) busy_nxt[wa[k]] = 1'b0;
    end
    if (iss_en) busy_nxt[iss_addr] = 1'b1;
    if (ZERO_REG) busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) busy_vec <= '0;
    else         busy_vec <= busy_nxt;
  end

  // Forwarded reads are never busy; neither is the hardwired zero register.
  always_comb begin
    rd_busy = '0;
    for (int unsigned p = 0; p < NUM_RD; p++) begin
      rd_busy[p] = busy_vec[ra[p]] && !rd_fwd[p] && !(ZERO_REG && (ra[p] == '0));
    end
  end

endmodule

// File: rtl/reg_bank_mp.sv
// Multi-port register bank with optional zero register, write-to-read bypass
// and a per-register busy scoreboard for RAW hazard detection.
module reg_bank_mp
  import reg_bank_pkg::*;
#(
  parameter int unsigned  DATA_W   = DEF_DATA_W,
  parameter int unsigned  NUM_REGS = DEF_NUM_REGS,
  parameter int unsigned  NUM_RD   = 2,
  parameter int unsigned  NUM_WR   = 2,
  parameter bit           ZERO_REG = 1'b1,
  parameter bit           BYPASS   = 1'b1,
  localparam int unsigned ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     arst_n,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_addr,
  output logic [NUM_REGS-1:0]      busy_vec
);

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [ADDR_W-1:0] wa   [NUM_WR];
  logic [DATA_W-1:0] wd   [NUM_WR];
  logic [ADDR_W-1:0] ra   [NUM_RD];
  logic [NUM_RD-1:0] rd_fwd;

  for (genvar k = 0; k < NUM_WR; k++) begin : g_wr
    assign wa[k] = wr_addr[k*ADDR_W +: ADDR_W];
    assign wd[k] = wr_data[k*DATA_W +: DATA_W];
  end

  // Ascending port order makes the highest-index port win on address conflicts.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int unsigned r = 0; r < NUM_REGS; r++) regs[r] <= '0;
    end else begin
      for (int unsigned k = 0; k < NUM_WR; k++) begin
        if (wr_en[k] && !(ZERO_REG && (wa[k] == '0))) regs[wa[k]] <= wd[k];
      end
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [NUM_WR-1:0] hit;
    logic [DATA_W-1:0] fwd;

    assign ra[p] = rd_addr[p*ADDR_W +: ADDR_W];

    // Select the winning write port's data for forwarding.
    always_comb begin
      hit = '0;
      fwd = '0;
      for (int unsigned k = 0; k < NUM_WR; k++) begin
        hit[k] = wr_en[k] && (wa[k] == ra[p]);
      end
      for (int unsigned k = 0; k < NUM_WR; k++) begin
        if (is_winner(MAX_PORTS'(hit), k)) fwd = wd[k];
      end
    end

    assign rd_fwd[p] = BYPASS && (|hit);
    assign rd_data[p*DATA_W +: DATA_W] = (ZERO_REG && (ra[p] == '0)) ? '0 :
                                         rd_fwd[p] ? fwd : regs[ra[p]];
  end

  reg_bank_sb #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W),
    .NUM_RD   (NUM_RD),
    .NUM_WR   (NUM_WR),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk      (clk),
    .arst_n   (arst_n),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .rd_addr  (rd_addr),
    .rd_fwd   (rd_fwd),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .busy_vec (busy_vec),
    .rd_busy  (rd_busy)
  );

endmodule

// File: tb/tb_reg_bank_mp.sv
// Bench for reg_bank_mp: bypass and non-bypass builds driven in parallel,
// directed scenarios followed by random traffic against an array-based model.
module tb_reg_bank_mp;

  logic        clk;
  logic        arst_n;
  logic [1:0]  wr_en;
  logic [9:0]  wr_addr;
  logic [63:0] wr_data;
  logic [9:0]  rd_addr;
  logic        iss_en;
  logic [4:0]  iss_addr;

  logic [63:0] rd_data_b,  rd_data_n;
  logic [1:0]  rd_busy_b,  rd_busy_n;
  logic [31:0] busy_vec_b, busy_vec_n;

  int tests = 0;
  int fails = 0;

  logic [31:0] mreg [32];
  logic [31:0] mbusy;

  reg_bank_mp #(.BYPASS(1'b1)) dut_b (
    .clk(clk), .arst_n(arst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
    .iss_en(iss_en), .iss_addr(iss_addr), .busy_vec(busy_vec_b)
  );

  reg_bank_mp #(.BYPASS(1'b0)) dut_n (
    .clk(clk), .arst_n(arst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data_n), .rd_busy(rd_busy_n),
    .iss_en(iss_en), .iss_addr(iss_addr), .busy_vec(busy_vec_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [1:0] en, input logic [4:0] a0, input logic [31:0] d0,
                       input logic [4:0] a1, input logic [31:0] d1,
                       input logic [4:0] r0, input logic [4:0] r1,
                       input logic ie, input logic [4:0] ia);
    wr_en    = en;
    wr_addr  = {a1, a0};
    wr_data  = {d1, d0};
    rd_addr  = {r1, r0};
    iss_en   = ie;
    iss_addr = ia;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) mreg[i] = '0;
    mbusy = '0;
  endtask

  // Register-file semantics: later ports overwrite earlier ones; issue beats writeback.
  task automatic model_update();
    logic [4:0] a;
    for (int k = 0; k < 2; k++) begin
      if (wr_en[k]) begin
        a = wr_addr[k*5 +: 5];
        if (a != 5'd0) mreg[a] = wr_data[k*32 +: 32];
        mbusy[a] = 1'b0;
      end
    end
    if (iss_en && iss_addr != 5'd0) mbusy[iss_addr] = 1'b1;
    mbusy[0] = 1'b0;
  endtask

  function automatic logic [31:0] exp_rd(input int p, input bit byp);
    logic [4:0]  a;
    logic [31:0] r;
    a = rd_addr[p*5 +: 5];
    if (a == 5'd0) return 32'd0;
    r = mreg[a];
    if (byp) begin
      for (int k = 0; k < 2; k++)
        if (wr_en[k] && wr_addr[k*5 +: 5] == a) r = wr_data[k*32 +: 32];
    end
    return r;
  endfunction

  function automatic logic exp_busy(input int p, input bit byp);
    logic [4:0] a;
    a = rd_addr[p*5 +: 5];
    if (a == 5'd0) return 1'b0;
    if (byp) begin
      for (int k = 0; k < 2; k++)
        if (wr_en[k] && wr_addr[k*5 +: 5] == a) return 1'b0;
    end
    return mbusy[a];
  endfunction

  task automatic check_model(input string tag);
    for (int p = 0; p < 2; p++) begin
      chk($sformatf("%s_byp_rd%0d", tag, p), rd_data_b[p*32 +: 32], exp_rd(p, 1'b1));
      chk($sformatf("%s_nob_rd%0d", tag, p), rd_data_n[p*32 +: 32], exp_rd(p, 1'b0));
      chk($sformatf("%s_byp_busy%0d", tag, p), 32'(rd_busy_b[p]), 32'(exp_busy(p, 1'b1)));
      chk($sformatf("%s_nob_busy%0d", tag, p), 32'(rd_busy_n[p]), 32'(exp_busy(p, 1'b0)));
    end
    chk({tag, "_byp_vec"}, busy_vec_b, mbusy);
    chk({tag, "_nob_vec"}, busy_vec_n, mbusy);
  endtask

  task automatic tick();
    @(posedge clk);
    if (arst_n) model_update();
    @(negedge clk);
  endtask

  task automatic idle(input logic [4:0] r0, input logic [4:0] r1);
    drive(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, r0, r1, 1'b0, 5'd0);
  endtask

  initial begin
    arst_n = 1'b0;
    idle(5'd1, 5'd2);
    model_clear();
    #2;
    chk("por_vec", busy_vec_b, 32'd0);
    check_model("por");
    @(negedge clk);
    arst_n = 1'b1;

    // Preload, then pull reset low mid-cycle.
    drive(2'b11, 5'd1, 32'h1111_1111, 5'd2, 32'h2222_2222, 5'd0, 5'd0, 1'b1, 5'd6);
    tick();
    idle(5'd1, 5'd2);
    #1;
    chk("pre_rd1", rd_data_n[31:0], 32'h1111_1111);
    chk("pre_busy6", 32'(busy_vec_b[6]), 32'd1);
    check_model("pre");
    #1 arst_n = 1'b0;
    #1;
    chk("arst_rd1", rd_data_b[31:0], 32'd0);
    chk("arst_rd2", rd_data_n[63:32], 32'd0);
    chk("arst_vec", busy_vec_b, 32'd0);
    model_clear();
    check_model("arst");
    tick();
    arst_n = 1'b1;

    // Dual write to one address: port 1 wins.
    drive(2'b11, 5'd5, 32'hAAAA_AAAA, 5'd5, 32'h5555_5555, 5'd5, 5'd0, 1'b0, 5'd0);
    #1;
    chk("dual_bypass", rd_data_b[31:0], 32'h5555_5555);
    check_model("dual_w");
    tick();
    idle(5'd5, 5'd5);
    #1;
    chk("dual_byp_after", rd_data_b[31:0], 32'h5555_5555);
    chk("dual_nob_after", rd_data_n[63:32], 32'h5555_5555);
    check_model("dual_r");

    // Zero register ignores writes and issues.
    drive(2'b01, 5'd0, 32'hDEAD_BEEF, 5'd0, 32'd0, 5'd0, 5'd0, 1'b1, 5'd0);
    #1;
    chk("zero_same", rd_data_b[31:0], 32'd0);
    tick();
    idle(5'd0, 5'd0);
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("zero_rd", rd_data_b[31:0], 32'd0);
      chk("zero_rd_nob", rd_data_n[63:32], 32'd0);
      chk("zero_busy", 32'(busy_vec_b[0]), 32'd0);
      tick();
    end

    // Scoreboard set on issue, cleared by writeback with forwarding.
    drive(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 5'd7, 1'b1, 5'd7);
    tick();
    idle(5'd0, 5'd7);
    #1;
    chk("iss7_vec", 32'(busy_vec_b[7]), 32'd1);
    chk("iss7_rdbusy", 32'(rd_busy_b[1]), 32'd1);
    drive(2'b01, 5'd7, 32'h0000_0015, 5'd0, 32'd0, 5'd0, 5'd7, 1'b0, 5'd0);
    #1;
    chk("wb7_rdbusy", 32'(rd_busy_b[1]), 32'd0);
    chk("wb7_fwd", rd_data_b[63:32], 32'h0000_0015);
    chk("wb7_nob_busy", 32'(rd_busy_n[1]), 32'd1);
    check_model("wb7");
    tick();
    idle(5'd7, 5'd7);
    #1;
    chk("wb7_clear", 32'(busy_vec_b[7]), 32'd0);

    // Issue and writeback to the same register in one cycle.
    drive(2'b10, 5'd0, 32'd0, 5'd3, 32'h0000_0033, 5'd3, 5'd0, 1'b1, 5'd3);
    tick();
    idle(5'd3, 5'd3);
    #1;
    chk("iw3_busy", 32'(busy_vec_b[3]), 32'd1);
    chk("iw3_data", rd_data_n[31:0], 32'h0000_0033);
    check_model("iw3");

    // Non-bypass build returns old value during the write cycle.
    drive(2'b01, 5'd9, 32'h0000_0015, 5'd0, 32'd0, 5'd0, 5'd0, 1'b0, 5'd0);
    tick();
    drive(2'b01, 5'd9, 32'h0000_0022, 5'd0, 32'd0, 5'd9, 5'd9, 1'b0, 5'd0);
    #1;
    chk("nob9_old", rd_data_n[31:0], 32'h0000_0015);
    chk("byp9_new", rd_data_b[63:32], 32'h0000_0022);
    tick();
    idle(5'd9, 5'd9);
    #1;
    chk("nob9_new", rd_data_n[31:0], 32'h0000_0022);

    // Random traffic, biased to a few addresses to provoke collisions.
    for (int i = 0; i < 400; i++) begin
      logic [4:0] a0, a1, r0, r1, ia;
      a0 = 5'($urandom_range(0, 7));
      a1 = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
      r0 = 5'($urandom_range(0, 7));
      r1 = ($urandom_range(0, 3) == 0) ? a1 : 5'($urandom_range(0, 7));
      ia = 5'($urandom_range(0, 7));
      drive(2'($urandom), a0, $urandom, a1, $urandom, r0, r1, 1'($urandom), ia);
      #1;
      check_model($sformatf("rnd%0d", i));
      if (i == 200) begin
        idle(r0, r1);
        #1 arst_n = 1'b0;
        #1;
        model_clear();
        check_model("rnd_arst");
        tick();
        arst_n = 1'b1;
      end else begin
        tick();
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
